// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one imem request at a time and holds the returned word for decode.
// Optional build macro PC_ALIGN_CHECK_EN adds a sticky misaligned-target flag and a HALT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  fun3,
  output logic        func7,
  input  logic [1:0]  N_PC,
  input  logic        branch_taken,
  input  logic [31:0] jump_target,
  output logic        pc_misaligned
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE} state_t;
`endif

  state_t      state, state_nxt;
  logic        idle_done;
  logic [31:0] pc_q, instr_q;
  logic [31:0] pc_plus4, pc_sel;
  logic        accept;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = (state == S_ISSUE) && instr_ready;

  always_comb begin
    pc_sel = pc_plus4;
    case (N_PC)
      2'b00:   pc_sel = pc_plus4;
      2'b01:   pc_sel = jump_target;
      2'b10:   pc_sel = branch_taken ? jump_target : pc_plus4;
      2'b11:   pc_sel = {jump_target[31:1], 1'b0};
      default: pc_sel = pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic target_bad;
  logic misaligned_q;
  assign target_bad    = |pc_sel[1:0];
  assign pc_misaligned = misaligned_q;
`else
  assign pc_misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (idle_done) state_nxt = S_REQ;
      S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_ISSUE;
`ifdef PC_ALIGN_CHECK_EN
      S_ISSUE: if (instr_ready) state_nxt = target_bad ? S_HALT : S_REQ;
      S_HALT:  state_nxt = S_HALT;
`else
      S_ISSUE: if (instr_ready) state_nxt = S_REQ;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // idle_done gives IDLE one full cycle after release before the first request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idle_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idle_done <= (state == S_IDLE);
    end
  end

  // instr returns to NOP as soon as the core accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      if ((state == S_WAIT) && imem_rsp_valid) instr_q <= imem_rsp_data;
      if (accept) begin
        instr_q <= NOP_INSTR;
        pc_q    <= pc_sel;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   misaligned_q <= 1'b0;
    else if (accept && target_bad) misaligned_q <= 1'b1;
  end
`endif

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state == S_ISSUE);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign opcode         = instr_q[6:0];
  assign fun3           = instr_q[14:12];
  assign func7          = instr_q[30];

endmodule
